// File: rtl/rv64_pipe_core.sv
`default_nettype none
// ============================================================================
// Module   : rv64_pipe_core
// Function : Five-stage in-order RV64 integer pipeline (add/sub/and/or/xor,
//            addi/andi/ori/xori, ld, sd, beq) with forwarding and ID branches.
// Revision : 1.0 - initial release
// ============================================================================
module rv64_pipe_core (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [63:0] o_dmem_addr,
    output logic [63:0] o_dmem_wdata,
    output logic        o_dmem_we,
    output logic        o_dmem_re,
    input  logic [63:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [63:0] o_wb_data
);

    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_LD  = 7'b0000011;
    localparam logic [6:0] c_OP_ST  = 7'b0100011;
    localparam logic [6:0] c_OP_BR  = 7'b1100011;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_XOR = 3'd4;

    // IF and IF/ID
    logic [63:0] r_pc;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [63:0] r_ifid_pc;

    // ID/EX
    logic        r_idex_rw, r_idex_mr, r_idex_mw, r_idex_alusrc;
    logic [2:0]  r_idex_aluop;
    logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
    logic [63:0] r_idex_a, r_idex_b, r_idex_imm;

    // EX/MEM
    logic        r_exmem_rw, r_exmem_mr, r_exmem_mw;
    logic [4:0]  r_exmem_rd;
    logic [63:0] r_exmem_alu, r_exmem_sdata;

    // MEM/WB
    logic        r_memwb_rw, r_memwb_mr;
    logic [4:0]  r_memwb_rd;
    logic [63:0] r_memwb_alu, r_memwb_ldata;

    logic [63:0] r_rf [0:31];

    // ---------------------------------------------------------------- decode
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_id_rw, w_id_mr, w_id_mw, w_id_alusrc, w_id_beq;
    logic        w_use_rs1, w_use_rs2;
    logic [2:0]  w_id_aluop;
    logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_id_imm;

    assign w_op  = r_ifid_instr[6:0];
    assign w_rd  = r_ifid_instr[11:7];
    assign w_f3  = r_ifid_instr[14:12];
    assign w_rs1 = r_ifid_instr[19:15];
    assign w_rs2 = r_ifid_instr[24:20];
    assign w_f7  = r_ifid_instr[31:25];

    assign w_imm_i  = {{52{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
    assign w_imm_s  = {{52{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
    assign w_imm_b  = {{52{r_ifid_instr[31]}}, r_ifid_instr[7], r_ifid_instr[30:25],
                       r_ifid_instr[11:8], 1'b0};
    assign w_id_imm = (w_op == c_OP_ST) ? w_imm_s : w_imm_i;

    always_comb begin
        w_id_rw     = 1'b0;
        w_id_mr     = 1'b0;
        w_id_mw     = 1'b0;
        w_id_alusrc = 1'b0;
        w_id_beq    = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_id_aluop  = c_ALU_ADD;
        if (r_ifid_valid) begin
            case (w_op)
                c_OP_R: begin
                    case (w_f3)
                        3'b000: begin
                            if (w_f7 == 7'h00) begin
                                w_id_rw = 1'b1;
                            end else if (w_f7 == 7'h20) begin
                                w_id_rw    = 1'b1;
                                w_id_aluop = c_ALU_SUB;
                            end
                        end
                        3'b100: begin w_id_rw = (w_f7 == 7'h00); w_id_aluop = c_ALU_XOR; end
                        3'b110: begin w_id_rw = (w_f7 == 7'h00); w_id_aluop = c_ALU_OR;  end
                        3'b111: begin w_id_rw = (w_f7 == 7'h00); w_id_aluop = c_ALU_AND; end
                        default: ;
                    endcase
                    w_use_rs1 = w_id_rw;
                    w_use_rs2 = w_id_rw;
                end
                c_OP_IMM: begin
                    case (w_f3)
                        3'b000:  begin w_id_rw = 1'b1; w_id_aluop = c_ALU_ADD; end
                        3'b100:  begin w_id_rw = 1'b1; w_id_aluop = c_ALU_XOR; end
                        3'b110:  begin w_id_rw = 1'b1; w_id_aluop = c_ALU_OR;  end
                        3'b111:  begin w_id_rw = 1'b1; w_id_aluop = c_ALU_AND; end
                        default: ;
                    endcase
                    w_id_alusrc = w_id_rw;
                    w_use_rs1   = w_id_rw;
                end
                c_OP_LD: begin
                    if (w_f3 == 3'b011) begin
                        w_id_rw     = 1'b1;
                        w_id_mr     = 1'b1;
                        w_id_alusrc = 1'b1;
                        w_use_rs1   = 1'b1;
                    end
                end
                c_OP_ST: begin
                    if (w_f3 == 3'b011) begin
                        w_id_mw     = 1'b1;
                        w_id_alusrc = 1'b1;
                        w_use_rs1   = 1'b1;
                        w_use_rs2   = 1'b1;
                    end
                end
                c_OP_BR: begin
                    if (w_f3 == 3'b000) begin
                        w_id_beq  = 1'b1;
                        w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------- register read and WB bypass
    logic        w_wb_we;
    logic [63:0] w_wb_data, w_rf_a, w_rf_b, w_br_a, w_br_b;
    logic        w_exmem_fwd_ok;

    assign w_wb_we   = r_memwb_rw && (r_memwb_rd != 5'd0);
    assign w_wb_data = r_memwb_mr ? r_memwb_ldata : r_memwb_alu;

    assign w_rf_a = (w_rs1 == 5'd0) ? 64'd0 :
                    (w_wb_we && (r_memwb_rd == w_rs1)) ? w_wb_data : r_rf[w_rs1];
    assign w_rf_b = (w_rs2 == 5'd0) ? 64'd0 :
                    (w_wb_we && (r_memwb_rd == w_rs2)) ? w_wb_data : r_rf[w_rs2];

    // A load in EX/MEM has no data yet, so only ALU results are forwardable.
    assign w_exmem_fwd_ok = r_exmem_rw && (r_exmem_rd != 5'd0) && !r_exmem_mr;
    assign w_br_a = (w_exmem_fwd_ok && (r_exmem_rd == w_rs1)) ? r_exmem_alu : w_rf_a;
    assign w_br_b = (w_exmem_fwd_ok && (r_exmem_rd == w_rs2)) ? r_exmem_alu : w_rf_b;

    // ----------------------------------------------------- hazards and branch
    logic        w_ld_use, w_br_stall, w_stall, w_taken;
    logic        w_idex_hit, w_exmem_ld_hit;
    logic [63:0] w_pc_next;

    assign w_idex_hit     = r_idex_rw && (r_idex_rd != 5'd0) &&
                            ((r_idex_rd == w_rs1) || (r_idex_rd == w_rs2));
    assign w_exmem_ld_hit = r_exmem_mr && (r_exmem_rd != 5'd0) &&
                            ((r_exmem_rd == w_rs1) || (r_exmem_rd == w_rs2));
    assign w_ld_use   = r_idex_mr && (r_idex_rd != 5'd0) &&
                        ((w_use_rs1 && (r_idex_rd == w_rs1)) ||
                         (w_use_rs2 && (r_idex_rd == w_rs2)));
    assign w_br_stall = w_id_beq && (w_idex_hit || w_exmem_ld_hit);
    assign w_stall    = w_ld_use || w_br_stall;
    assign w_taken    = w_id_beq && !w_br_stall && (w_br_a == w_br_b);
    assign w_pc_next  = w_taken ? (r_ifid_pc + w_imm_b) :
                        w_stall ? r_pc : (r_pc + 64'd4);

    // ----------------------------------------------------------------- EX
    logic [63:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu;

    always_comb begin
        w_fwd_a = r_idex_a;
        if (w_exmem_fwd_ok && (r_exmem_rd == r_idex_rs1)) begin
            w_fwd_a = r_exmem_alu;
        end else if (w_wb_we && (r_memwb_rd == r_idex_rs1)) begin
            w_fwd_a = w_wb_data;
        end
        w_fwd_b = r_idex_b;
        if (w_exmem_fwd_ok && (r_exmem_rd == r_idex_rs2)) begin
            w_fwd_b = r_exmem_alu;
        end else if (w_wb_we && (r_memwb_rd == r_idex_rs2)) begin
            w_fwd_b = w_wb_data;
        end
    end

    assign w_alu_b = r_idex_alusrc ? r_idex_imm : w_fwd_b;

    always_comb begin
        case (r_idex_aluop)
            c_ALU_SUB: w_alu = w_fwd_a - w_alu_b;
            c_ALU_AND: w_alu = w_fwd_a & w_alu_b;
            c_ALU_OR:  w_alu = w_fwd_a | w_alu_b;
            c_ALU_XOR: w_alu = w_fwd_a ^ w_alu_b;
            default:   w_alu = w_fwd_a + w_alu_b;
        endcase
    end

    // ----------------------------------------------------------- pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= 64'd0;
            r_ifid_valid  <= 1'b0;
            r_ifid_instr  <= 32'd0;
            r_ifid_pc     <= 64'd0;
            r_idex_rw     <= 1'b0;
            r_idex_mr     <= 1'b0;
            r_idex_mw     <= 1'b0;
            r_idex_alusrc <= 1'b0;
            r_idex_aluop  <= c_ALU_ADD;
            r_idex_rs1    <= 5'd0;
            r_idex_rs2    <= 5'd0;
            r_idex_rd     <= 5'd0;
            r_idex_a      <= 64'd0;
            r_idex_b      <= 64'd0;
            r_idex_imm    <= 64'd0;
            r_exmem_rw    <= 1'b0;
            r_exmem_mr    <= 1'b0;
            r_exmem_mw    <= 1'b0;
            r_exmem_rd    <= 5'd0;
            r_exmem_alu   <= 64'd0;
            r_exmem_sdata <= 64'd0;
            r_memwb_rw    <= 1'b0;
            r_memwb_mr    <= 1'b0;
            r_memwb_rd    <= 5'd0;
            r_memwb_alu   <= 64'd0;
            r_memwb_ldata <= 64'd0;
        end else begin
            r_pc <= w_pc_next;
            if (w_taken) begin
                r_ifid_valid <= 1'b0;
            end else if (!w_stall) begin
                r_ifid_valid <= 1'b1;
                r_ifid_instr <= i_imem_rdata;
                r_ifid_pc    <= r_pc;
            end

            r_idex_rw     <= w_id_rw && !w_stall;
            r_idex_mr     <= w_id_mr && !w_stall;
            r_idex_mw     <= w_id_mw && !w_stall;
            r_idex_alusrc <= w_id_alusrc;
            r_idex_aluop  <= w_id_aluop;
            r_idex_rs1    <= w_rs1;
            r_idex_rs2    <= w_rs2;
            r_idex_rd     <= w_stall ? 5'd0 : w_rd;
            r_idex_a      <= w_rf_a;
            r_idex_b      <= w_rf_b;
            r_idex_imm    <= w_id_imm;

            r_exmem_rw    <= r_idex_rw;
            r_exmem_mr    <= r_idex_mr;
            r_exmem_mw    <= r_idex_mw;
            r_exmem_rd    <= r_idex_rd;
            r_exmem_alu   <= w_alu;
            r_exmem_sdata <= w_fwd_b;

            r_memwb_rw    <= r_exmem_rw;
            r_memwb_mr    <= r_exmem_mr;
            r_memwb_rd    <= r_exmem_rd;
            r_memwb_alu   <= r_exmem_alu;
            r_memwb_ldata <= i_dmem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 64'd0;
            end
        end else if (w_wb_we) begin
            r_rf[r_memwb_rd] <= w_wb_data;
        end
    end

    // Strobes are masked by rst so a store sitting in MEM cannot land on the reset edge.
    assign o_imem_addr  = r_pc;
    assign o_dmem_addr  = r_exmem_alu;
    assign o_dmem_wdata = r_exmem_sdata;
    assign o_dmem_we    = r_exmem_mw && !rst;
    assign o_dmem_re    = r_exmem_mr && !rst;
    assign o_wb_valid   = w_wb_we;
    assign o_wb_rd      = r_memwb_rd;
    assign o_wb_data    = w_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_rv64_pipe_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv64_pipe_core
// Function : Directed program bench for rv64_pipe_core with a per-cycle WB table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv64_pipe_core;

    localparam logic [6:0] c_OPI = 7'b0010011;
    localparam logic [6:0] c_LD  = 7'b0000011;
    localparam int         c_NCYC = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, wb_data;
    logic [31:0] imem_rdata;
    logic        dmem_we, dmem_re, wb_valid;
    logic [4:0]  wb_rd;

    logic [31:0] imem [0:63];
    logic [63:0] dmem [0:31];
    logic        tb_wr = 1'b0;
    logic [4:0]  tb_wa = 5'd0;
    logic [63:0] tb_wd = 64'd0;

    logic [4:0]  e_rd  [0:c_NCYC-1];
    logic [63:0] e_dat [0:c_NCYC-1];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv64_pipe_core u_dut (
        .clk          (clk),
        .rst          (rst),
        .o_imem_addr  (imem_addr),
        .i_imem_rdata (imem_rdata),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_wdata (dmem_wdata),
        .o_dmem_we    (dmem_we),
        .o_dmem_re    (dmem_re),
        .i_dmem_rdata (dmem_rdata),
        .o_wb_valid   (wb_valid),
        .o_wb_rd      (wb_rd),
        .o_wb_data    (wb_data)
    );

    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_rdata = dmem[dmem_addr[7:3]];

    always @(posedge clk) begin
        if (tb_wr) begin
            dmem[tb_wa] <= tb_wd;
        end else if (dmem_we) begin
            dmem[dmem_addr[7:3]] <= dmem_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic poke(input logic [4:0] a, input logic [63:0] d);
        tb_wa = a;
        tb_wd = d;
        tb_wr = 1'b1;
        @(posedge clk);
        #1 tb_wr = 1'b0;
    endtask

    // Leaves the bench 1 time unit into cycle 0 (the cycle that fetches address 0).
    task automatic do_reset();
        rst = 1'b1;
        poke(5'd8, 64'h0000_0000_0000_F0F0);
        poke(5'd9, 64'h0000_0000_0000_0FF0);
        poke(5'd2, 64'h0000_0000_0000_DEAD);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " pc"},      imem_addr, 64'd0);
        check_val({tag, " wbv"},     {63'd0, wb_valid}, 64'd0);
        check_val({tag, " wbrd"},    {59'd0, wb_rd}, 64'd0);
        check_val({tag, " wbdata"},  wb_data, 64'd0);
        check_val({tag, " we"},      {63'd0, dmem_we}, 64'd0);
        check_val({tag, " re"},      {63'd0, dmem_re}, 64'd0);
    endtask

    task automatic set_exp(input int c, input logic [4:0] rd, input logic [63:0] d);
        e_rd[c]  = rd;
        e_dat[c] = d;
    endtask

    task automatic run_prog(input string tag);
        logic [63:0] fetch_exp [0:3];
        fetch_exp[0] = 64'h58;
        fetch_exp[1] = 64'h5C;
        fetch_exp[2] = 64'h5C;
        fetch_exp[3] = 64'h60;
        for (int c = 0; c < c_NCYC; c++) begin
            @(negedge clk);
            check_val($sformatf("%s c%0d wbv", tag, c), {63'd0, wb_valid},
                      {63'd0, (e_rd[c] != 5'd0)});
            if (e_rd[c] != 5'd0) begin
                check_val($sformatf("%s c%0d wbrd", tag, c), {59'd0, wb_rd}, {59'd0, e_rd[c]});
                check_val($sformatf("%s c%0d wbdata", tag, c), wb_data, e_dat[c]);
            end
            check_val($sformatf("%s c%0d we", tag, c), {63'd0, dmem_we}, {63'd0, (c == 8)});
            check_val($sformatf("%s c%0d re", tag, c), {63'd0, dmem_re},
                      {63'd0, (c == 9 || c == 12 || c == 13)});
            if (c == 8) begin
                check_val({tag, " sd addr"}, dmem_addr, 64'd16);
                check_val({tag, " sd data"}, dmem_wdata, 64'd12);
            end
            if (c >= 24 && c <= 27) begin
                check_val($sformatf("%s c%0d fetch", tag, c), imem_addr, fetch_exp[c-24]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 32; i++) dmem[i] = 64'd0;
        imem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, c_OPI);
        imem[1]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2, c_OPI);
        imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        imem[3]  = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4);
        imem[4]  = enc_i(12'd16, 5'd0, 3'b000, 5'd5, c_OPI);
        imem[5]  = enc_s(12'd0, 5'd3, 5'd5);
        imem[6]  = enc_i(12'd0, 5'd5, 3'b011, 5'd6, c_LD);
        imem[7]  = enc_r(7'h00, 5'd6, 5'd6, 3'b000, 5'd7);
        imem[8]  = enc_i(12'd64, 5'd0, 3'b011, 5'd10, c_LD);
        imem[9]  = enc_i(12'd72, 5'd0, 3'b011, 5'd11, c_LD);
        imem[10] = enc_r(7'h00, 5'd11, 5'd10, 3'b111, 5'd12);
        imem[11] = enc_r(7'h00, 5'd11, 5'd10, 3'b110, 5'd13);
        imem[12] = enc_r(7'h00, 5'd11, 5'd10, 3'b100, 5'd14);
        imem[13] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd15, c_OPI);
        imem[14] = enc_i(12'd9, 5'd0, 3'b000, 5'd0, c_OPI);
        imem[15] = enc_r(7'h00, 5'd15, 5'd0, 3'b000, 5'd16);
        imem[16] = enc_r(7'h00, 5'd15, 5'd0, 3'b000, 5'd17);
        imem[17] = enc_b(13'd8, 5'd0, 5'd1);
        imem[18] = enc_i(12'd2, 5'd0, 3'b000, 5'd18, c_OPI);
        imem[19] = enc_i(12'd3, 5'd0, 3'b000, 5'd19, c_OPI);
        imem[20] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, c_OPI);
        imem[21] = enc_i(12'd3, 5'd0, 3'b000, 5'd2, c_OPI);
        imem[22] = enc_b(13'd8, 5'd2, 5'd1);
        imem[23] = enc_i(12'd1, 5'd0, 3'b000, 5'd8, c_OPI);
        imem[24] = enc_i(12'd2, 5'd0, 3'b000, 5'd9, c_OPI);

        for (int c = 0; c < c_NCYC; c++) set_exp(c, 5'd0, 64'd0);
        set_exp(4,  5'd1,  64'd5);
        set_exp(5,  5'd2,  64'd7);
        set_exp(6,  5'd3,  64'd12);
        set_exp(7,  5'd4,  64'd7);
        set_exp(8,  5'd5,  64'd16);
        set_exp(10, 5'd6,  64'd12);
        set_exp(12, 5'd7,  64'd24);
        set_exp(13, 5'd10, 64'h0000_0000_0000_F0F0);
        set_exp(14, 5'd11, 64'h0000_0000_0000_0FF0);
        set_exp(16, 5'd12, 64'h0000_0000_0000_00F0);
        set_exp(17, 5'd13, 64'h0000_0000_0000_FFF0);
        set_exp(18, 5'd14, 64'h0000_0000_0000_FF00);
        set_exp(19, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF);
        set_exp(21, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF);
        set_exp(22, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
        set_exp(24, 5'd18, 64'd2);
        set_exp(25, 5'd19, 64'd3);
        set_exp(26, 5'd1,  64'd3);
        set_exp(27, 5'd2,  64'd3);
        set_exp(31, 5'd9,  64'd2);

        do_reset();
        check_reset_state("rst0");
        run_prog("run1");
        check_val("run1 mem16", dmem[2], 64'd12);

        // Reset lands while the sd is in MEM.
        do_reset();
        for (int c = 0; c <= 8; c++) @(negedge clk);
        check_val("mid sd inflight", {63'd0, dmem_we}, 64'd1);
        rst = 1'b1;
        #1;
        check_val("mid we masked", {63'd0, dmem_we}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("mid");
        check_val("mid mem16 kept", dmem[2], 64'h0000_0000_0000_DEAD);
        run_prog("run2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
